// File: rtl/wash_cycle_sequencer.sv
// Washer programme sequencer: times lock/fill/wash/drain/rinse/spin phases and supervises lid/fill/drain sensors.
// Optional macro PAUSE_HOLD_EN adds a pause input that freezes the timed phases.
module wash_cycle_sequencer #(
  parameter int TICK_DIV      = 1000,
  parameter int FILL_TIMEOUT  = 60,
  parameter int DRAIN_TIMEOUT = 30,
  parameter int RINSE_UNITS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       fault_clr,
  input  logic [1:0] cycle_select,
  input  logic [1:0] water_level_select,
  input  logic       lid_closed,
  input  logic       water_full,
  input  logic       water_empty,
`ifdef PAUSE_HOLD_EN
  input  logic       pause,
`endif
  output logic       door_locked,
  output logic       pump_in,
  output logic       pump_out,
  output logic       motor_on,
  output logic [3:0] phase,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOCK  = 4'd1,
    ST_FILL  = 4'd2,
    ST_WASH  = 4'd3,
    ST_DRAIN = 4'd4,
    ST_RINSE = 4'd5,
    ST_SPIN  = 4'd6,
    ST_DONE  = 4'd7,
    ST_FAULT = 4'd8
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   presc_r;
  logic [7:0]      remaining_r, load_s;
  logic            pass_r, pass_s;
  logic            abort_r, abort_s;
  logic [1:0]      fault_code_r, fault_code_s;
  logic            tick_s, last_s, hold_s, lid_fault_s;
  logic            door_locked_r, pump_in_r, pump_out_r, motor_on_r, busy_r, done_r, fault_r;
  logic            door_locked_s, pump_in_s, pump_out_s, motor_on_s, busy_s, done_s, fault_s;
  logic [3:0]      phase_r;

  function automatic logic [7:0] wash_units(input logic [1:0] sel);
    case (sel)
      2'b00:   wash_units = 8'd5;
      2'b01:   wash_units = 8'd10;
      2'b10:   wash_units = 8'd15;
      default: wash_units = 8'd8;
    endcase
  endfunction

  function automatic logic [7:0] spin_units(input logic [1:0] sel);
    case (sel)
      2'b00:   spin_units = 8'd3;
      2'b01:   spin_units = 8'd5;
      default: spin_units = 8'd7;
    endcase
  endfunction

`ifdef PAUSE_HOLD_EN
  assign hold_s = pause && ((state_r == ST_WASH) || (state_r == ST_RINSE) || (state_r == ST_SPIN));
`else
  assign hold_s = 1'b0;
`endif

  assign tick_s      = (presc_r == PW'(TICK_DIV - 1)) && !hold_s;
  assign last_s      = (remaining_r <= 8'd1);
  assign lid_fault_s = !lid_closed && (state_r >= ST_LOCK) && (state_r <= ST_SPIN);

  // Next-state, pass/abort latches and fault code selection
  always_comb begin
    state_s      = state_r;
    pass_s       = pass_r;
    abort_s      = abort_r;
    fault_code_s = fault_code_r;
    if (lid_fault_s) begin
      state_s      = ST_FAULT;
      fault_code_s = 2'b11;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pass_s  = 1'b0;
          abort_s = 1'b0;
          if (start && lid_closed) begin
            state_s = ST_LOCK;
          end else if (start) begin
            state_s      = ST_FAULT;
            fault_code_s = 2'b11;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOCK: state_s = ST_FILL;
        ST_FILL: begin
          if (abort) begin
            state_s = ST_DRAIN;
            abort_s = 1'b1;
          end else if (water_full) begin
            state_s = pass_r ? ST_RINSE : ST_WASH;
          end else if (tick_s && last_s) begin
            state_s      = ST_FAULT;
            fault_code_s = 2'b01;
          end else begin
            state_s = ST_FILL;
          end
        end
        ST_WASH, ST_RINSE, ST_SPIN: begin
          if (abort) begin
            state_s = ST_DRAIN;
            abort_s = 1'b1;
          end else if (tick_s && last_s) begin
            state_s = (state_r == ST_SPIN) ? ST_DONE : ST_DRAIN;
          end else begin
            state_s = state_r;
          end
        end
        ST_DRAIN: begin
          abort_s = abort_r || abort;
          if (water_empty) begin
            if (abort_r || abort) begin
              state_s = ST_IDLE;
            end else if (pass_r) begin
              state_s = ST_SPIN;
            end else begin
              state_s = ST_FILL;
              pass_s  = 1'b1;
            end
          end else if (tick_s && last_s) begin
            state_s      = ST_FAULT;
            fault_code_s = 2'b10;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        ST_FAULT: begin
          if (fault_clr && water_empty) begin
            state_s      = ST_IDLE;
            fault_code_s = 2'b00;
          end else begin
            state_s = ST_FAULT;
          end
        end
        default: begin
          state_s      = ST_IDLE;
          fault_code_s = 2'b00;
        end
      endcase
    end
  end

  // Duration loaded on phase entry; selects are only looked at here
  always_comb begin
    case (state_s)
      ST_FILL:  load_s = 8'(FILL_TIMEOUT);
      ST_WASH:  load_s = wash_units(cycle_select);
      ST_DRAIN: load_s = 8'(DRAIN_TIMEOUT);
      ST_RINSE: load_s = 8'(RINSE_UNITS);
      ST_SPIN:  load_s = spin_units(water_level_select);
      default:  load_s = 8'd0;
    endcase
  end

  // Moore decode of the state being entered, so registered outputs line up with the state
  always_comb begin
    door_locked_s = 1'b0;
    pump_in_s     = 1'b0;
    pump_out_s    = 1'b0;
    motor_on_s    = 1'b0;
    busy_s        = 1'b0;
    fault_s       = 1'b0;
    case (state_s)
      ST_LOCK: begin
        door_locked_s = 1'b1;
        busy_s        = 1'b1;
      end
      ST_FILL: begin
        door_locked_s = 1'b1;
        pump_in_s     = 1'b1;
        busy_s        = 1'b1;
      end
      ST_WASH, ST_RINSE: begin
        door_locked_s = 1'b1;
        motor_on_s    = !hold_s;
        busy_s        = 1'b1;
      end
      ST_DRAIN: begin
        door_locked_s = 1'b1;
        pump_out_s    = 1'b1;
        busy_s        = 1'b1;
      end
      ST_SPIN: begin
        door_locked_s = 1'b1;
        motor_on_s    = !hold_s;
        pump_out_s    = 1'b1;
        busy_s        = 1'b1;
      end
      ST_DONE: busy_s = 1'b1;
      ST_FAULT: begin
        // Keep the door shut while water remains in the drum
        door_locked_s = !water_empty;
        fault_s       = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  assign done_s = (state_r == ST_DONE) && (state_s == ST_IDLE);

  // Programme state, prescaler, phase countdown and fault latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      presc_r      <= {PW{1'b0}};
      remaining_r  <= 8'd0;
      pass_r       <= 1'b0;
      abort_r      <= 1'b0;
      fault_code_r <= 2'b00;
    end else begin
      state_r      <= state_s;
      pass_r       <= pass_s;
      abort_r      <= abort_s;
      fault_code_r <= fault_code_s;
      if (state_s != state_r) begin
        presc_r     <= {PW{1'b0}};
        remaining_r <= load_s;
      end else if (hold_s) begin
        presc_r     <= presc_r;
        remaining_r <= remaining_r;
      end else if (tick_s) begin
        presc_r     <= {PW{1'b0}};
        remaining_r <= (remaining_r != 8'd0) ? (remaining_r - 8'd1) : 8'd0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Registered actuator and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      door_locked_r <= 1'b0;
      pump_in_r     <= 1'b0;
      pump_out_r    <= 1'b0;
      motor_on_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      fault_r       <= 1'b0;
      phase_r       <= 4'd0;
    end else begin
      door_locked_r <= door_locked_s;
      pump_in_r     <= pump_in_s;
      pump_out_r    <= pump_out_s;
      motor_on_r    <= motor_on_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      fault_r       <= fault_s;
      phase_r       <= state_s;
    end
  end

  assign door_locked = door_locked_r;
  assign pump_in     = pump_in_r;
  assign pump_out    = pump_out_r;
  assign motor_on    = motor_on_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign fault       = fault_r;
  assign phase       = phase_r;
  assign remaining   = remaining_r;
  assign fault_code  = fault_code_r;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: a per-cycle plan of expected phases is built from phase durations
// and sensor timings, then replayed against the DUT (pause scenario only when PAUSE_HOLD_EN is defined).
module tb_wash_cycle_sequencer;
  localparam int TD = 4;
  localparam int FT = 5;
  localparam int DT = 6;
  localparam int RU = 4;

  localparam logic [3:0] P_IDLE = 4'd0, P_LOCK = 4'd1, P_FILL = 4'd2, P_WASH = 4'd3, P_DRAIN = 4'd4;
  localparam logic [3:0] P_RINSE = 4'd5, P_SPIN = 4'd6, P_DONE = 4'd7, P_FAULT = 4'd8;

  logic clk = 1'b0;
  logic reset, start, abort, fault_clr, lid_closed, water_full, water_empty;
  logic [1:0] cycle_select, water_level_select;
`ifdef PAUSE_HOLD_EN
  logic pause;
`endif
  logic door_locked, pump_in, pump_out, motor_on, busy, done, fault;
  logic [3:0] phase;
  logic [7:0] remaining;
  logic [1:0] fault_code;

  wash_cycle_sequencer #(.TICK_DIV(TD), .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT), .RINSE_UNITS(RU)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .fault_clr(fault_clr),
    .cycle_select(cycle_select), .water_level_select(water_level_select),
    .lid_closed(lid_closed), .water_full(water_full), .water_empty(water_empty),
`ifdef PAUSE_HOLD_EN
    .pause(pause),
`endif
    .door_locked(door_locked), .pump_in(pump_in), .pump_out(pump_out), .motor_on(motor_on),
    .phase(phase), .remaining(remaining), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ph;
    logic [7:0] rem;
    logic       dn;
    logic [1:0] code;
    logic       full, empty, lid, abrt, start, clr, pse;
    logic [1:0] cs, ls;
  } step_t;

  step_t plan[$];
  int checks = 0;
  int errors = 0;
  logic i_full, i_empty, i_lid, i_abort, i_start, i_clr, i_pause, sel_hold;
  logic [1:0] cur_c, cur_l;
  int age = 0;
  logic prev_empty, prev_pause;
  logic [3:0] prev_ph;
  int mode, at;
  logic [1:0] rc, rl;

  function automatic int wash_len(input logic [1:0] c);
    return (c == 2'd0) ? 5 : (c == 2'd1) ? 10 : (c == 2'd2) ? 15 : 8;
  endfunction

  function automatic int spin_len(input logic [1:0] l);
    return (l == 2'd0) ? 3 : (l == 2'd1) ? 5 : 7;
  endfunction

  function automatic bit timed(input logic [3:0] p);
    return (p == P_WASH) || (p == P_RINSE) || (p == P_SPIN);
  endfunction

  // Append n cycles of one phase; rem0 > 0 means the phase counts down from rem0 units
  task automatic seg(input logic [3:0] ph, input int n, input bit fresh, input int rem0,
                     input logic [1:0] code, input logic dn);
    step_t s;
    if (fresh) age = 0;
    for (int i = 0; i < n; i++) begin
      s.ph = ph;
      s.rem = (rem0 > 0) ? 8'(rem0 - age / TD) : 8'd0;
      s.dn = dn; s.code = code;
      s.full = i_full; s.empty = i_empty; s.lid = i_lid; s.abrt = i_abort;
      s.start = i_start; s.clr = i_clr; s.pse = i_pause;
      s.cs = sel_hold ? cur_c : 2'($urandom_range(0, 3));
      s.ls = sel_hold ? cur_l : 2'($urandom_range(0, 3));
      plan.push_back(s);
      if (!(i_pause && timed(ph))) age++;
    end
  endtask

  task automatic idle_inputs();
    i_full = 1'b0; i_empty = 1'b1; i_lid = 1'b1; i_abort = 1'b0;
    i_start = 1'b0; i_clr = 1'b0; i_pause = 1'b0; sel_hold = 1'b0;
  endtask

  // mode 0 normal, 1 abort in WASH at cycle at, 2 lid opens in SPIN at cycle at,
  // 3 first drain never empties, 4 pause 9 cycles in WASH from cycle at
  task automatic programme(input logic [1:0] c, input logic [1:0] l, input int fk1, input int ek1,
                           input int fk2, input int ek2, input int md, input int pt);
    int wl, sl;
    wl = wash_len(c) * TD;
    sl = spin_len(l) * TD;
    cur_c = c; cur_l = l;
    idle_inputs();
    i_start = 1'b1; seg(P_IDLE, 1, 1, 0, 2'b00, 1'b0);
    i_start = 1'b0; seg(P_LOCK, 1, 1, 0, 2'b00, 1'b0);
    i_empty = 1'b0; seg(P_FILL, fk1, 1, FT, 2'b00, 1'b0);
    i_full = 1'b1; sel_hold = 1'b1; seg(P_FILL, 1, 0, FT, 2'b00, 1'b0); sel_hold = 1'b0;
    if (md == 1) begin
      seg(P_WASH, pt, 1, wash_len(c), 2'b00, 1'b0);
      i_abort = 1'b1; seg(P_WASH, 1, 0, wash_len(c), 2'b00, 1'b0); i_abort = 1'b0;
      i_full = 1'b0; seg(P_DRAIN, ek1, 1, DT, 2'b00, 1'b0);
      i_empty = 1'b1; seg(P_DRAIN, 1, 0, DT, 2'b00, 1'b0);
      seg(P_IDLE, 2, 1, 0, 2'b00, 1'b0);
      return;
    end
    if (md == 4) begin
      seg(P_WASH, pt, 1, wash_len(c), 2'b00, 1'b0);
      i_pause = 1'b1; seg(P_WASH, 9, 0, wash_len(c), 2'b00, 1'b0); i_pause = 1'b0;
      seg(P_WASH, wl - pt, 0, wash_len(c), 2'b00, 1'b0);
    end else begin
      seg(P_WASH, wl, 1, wash_len(c), 2'b00, 1'b0);
    end
    i_full = 1'b0;
    if (md == 3) begin
      seg(P_DRAIN, DT * TD, 1, DT, 2'b00, 1'b0);
      seg(P_FAULT, 2, 1, 0, 2'b10, 1'b0);
      i_clr = 1'b1; seg(P_FAULT, 1, 0, 0, 2'b10, 1'b0);
      i_empty = 1'b1; seg(P_FAULT, 1, 0, 0, 2'b10, 1'b0);
      i_clr = 1'b0; seg(P_IDLE, 2, 1, 0, 2'b00, 1'b0);
      return;
    end
    seg(P_DRAIN, ek1, 1, DT, 2'b00, 1'b0);
    i_empty = 1'b1; seg(P_DRAIN, 1, 0, DT, 2'b00, 1'b0);
    i_empty = 1'b0; seg(P_FILL, fk2, 1, FT, 2'b00, 1'b0);
    i_full = 1'b1; seg(P_FILL, 1, 0, FT, 2'b00, 1'b0);
    seg(P_RINSE, RU * TD, 1, RU, 2'b00, 1'b0);
    i_full = 1'b0; seg(P_DRAIN, ek2, 1, DT, 2'b00, 1'b0);
    i_empty = 1'b1; sel_hold = 1'b1; seg(P_DRAIN, 1, 0, DT, 2'b00, 1'b0); sel_hold = 1'b0;
    if (md == 2) begin
      seg(P_SPIN, pt, 1, spin_len(l), 2'b00, 1'b0);
      i_lid = 1'b0; seg(P_SPIN, 1, 0, spin_len(l), 2'b00, 1'b0);
      seg(P_FAULT, 2, 1, 0, 2'b11, 1'b0);
      i_clr = 1'b1; seg(P_FAULT, 1, 0, 0, 2'b11, 1'b0);
      i_clr = 1'b0; i_lid = 1'b1; seg(P_IDLE, 2, 1, 0, 2'b00, 1'b0);
      return;
    end
    seg(P_SPIN, sl, 1, spin_len(l), 2'b00, 1'b0);
    seg(P_DONE, 1, 1, 0, 2'b00, 1'b0);
    seg(P_IDLE, 1, 1, 0, 2'b00, 1'b1);
    seg(P_IDLE, 1, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Replay n planned cycles (all when n < 0); entered and left at posedge+1
  task automatic play(input int n);
    step_t s;
    logic [5:0] act;
    int cnt;
    cnt = 0;
    while (plan.size() > 0 && (n < 0 || cnt < n)) begin
      s = plan.pop_front();
      cnt++;
      start = s.start; abort = s.abrt; fault_clr = s.clr; lid_closed = s.lid;
      water_full = s.full; water_empty = s.empty;
      cycle_select = s.cs; water_level_select = s.ls;
`ifdef PAUSE_HOLD_EN
      pause = s.pse;
`endif
      @(negedge clk);
      act[5] = ((s.ph >= P_LOCK) && (s.ph <= P_SPIN)) || ((s.ph == P_FAULT) && !prev_empty);
      act[4] = (s.ph == P_FILL);
      act[3] = (s.ph == P_DRAIN) || (s.ph == P_SPIN);
      act[2] = timed(s.ph) && !(prev_pause && (prev_ph == s.ph));
      act[1] = (s.ph >= P_LOCK) && (s.ph <= P_DONE);
      act[0] = (s.ph == P_FAULT);
      check("phase", 16'(phase), 16'(s.ph));
      check("remaining", 16'(remaining), 16'(s.rem));
      check("actuators", 16'({door_locked, pump_in, pump_out, motor_on, busy, fault}), 16'(act));
      check("done", 16'(done), 16'(s.dn));
      check("fault_code", 16'(fault_code), 16'(s.code));
      prev_empty = s.empty; prev_pause = s.pse; prev_ph = s.ph;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_phase"}, 16'(phase), 16'd0);
    check({tag, "_remaining"}, 16'(remaining), 16'd0);
    check({tag, "_outputs"}, 16'({door_locked, pump_in, pump_out, motor_on, busy, done, fault, fault_code}), 16'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; fault_clr = 1'b0; lid_closed = 1'b1;
    water_full = 1'b0; water_empty = 1'b1; cycle_select = 2'b00; water_level_select = 2'b00;
`ifdef PAUSE_HOLD_EN
    pause = 1'b0;
`endif
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    prev_empty = 1'b1; prev_pause = 1'b0; prev_ph = P_IDLE;

    // Full programme with the reference sensor timings
    programme(2'b00, 2'b00, 3 * TD, 2 * TD, 3 * TD, 2 * TD, 0, 0); play(-1);

    // Start with lid open, then fault_clr ignored while drum holds water
    idle_inputs();
    i_start = 1'b1; i_lid = 1'b0; seg(P_IDLE, 1, 1, 0, 2'b00, 1'b0);
    i_start = 1'b0; seg(P_FAULT, 2, 1, 0, 2'b11, 1'b0);
    i_empty = 1'b0; i_clr = 1'b1; seg(P_FAULT, 2, 0, 0, 2'b11, 1'b0);
    i_empty = 1'b1; seg(P_FAULT, 1, 0, 0, 2'b11, 1'b0);
    i_clr = 1'b0; i_lid = 1'b1; seg(P_IDLE, 2, 1, 0, 2'b00, 1'b0);
    play(-1);

    // Fill timeout
    idle_inputs();
    i_start = 1'b1; seg(P_IDLE, 1, 1, 0, 2'b00, 1'b0);
    i_start = 1'b0; seg(P_LOCK, 1, 1, 0, 2'b00, 1'b0);
    i_empty = 1'b0; seg(P_FILL, FT * TD, 1, FT, 2'b00, 1'b0);
    seg(P_FAULT, 2, 1, 0, 2'b01, 1'b0);
    i_empty = 1'b1; i_clr = 1'b1; seg(P_FAULT, 1, 0, 0, 2'b01, 1'b0);
    i_clr = 1'b0; seg(P_IDLE, 2, 1, 0, 2'b00, 1'b0);
    play(-1);

    // Abort at WASH remaining 7, lid opens on the SPIN expiry tick
    programme(2'b01, 2'b01, 5, 7, 5, 7, 1, 13); play(-1);
    programme(2'b10, 2'b11, 2, 3, 4, 1, 2, spin_len(2'b11) * TD - 1); play(-1);
    // Sensors arriving on the timeout tick win; drain timeout
    programme(2'b11, 2'b10, FT * TD - 1, DT * TD - 1, FT * TD - 1, DT * TD - 1, 0, 0); play(-1);
    programme(2'b00, 2'b01, 1, 0, 0, 0, 3, 0); play(-1);
`ifdef PAUSE_HOLD_EN
    programme(2'b01, 2'b00, 4, 4, 4, 4, 4, 10); play(-1);
`endif

    for (int k = 0; k < 10; k++) begin
      rc = 2'($urandom_range(0, 3));
      rl = 2'($urandom_range(0, 3));
`ifdef PAUSE_HOLD_EN
      mode = int'($urandom_range(0, 4));
`else
      mode = int'($urandom_range(0, 3));
`endif
      if (mode == 2) at = int'($urandom_range(0, spin_len(rl) * TD - 1));
      else at = int'($urandom_range(0, wash_len(rc) * TD - 1));
      programme(rc, rl, int'($urandom_range(0, FT * TD - 1)), int'($urandom_range(0, DT * TD - 1)),
                int'($urandom_range(0, FT * TD - 1)), int'($urandom_range(0, DT * TD - 1)), mode, at);
      play(-1);
    end

    // Reset in the middle of WASH returns straight to IDLE
    programme(2'b01, 2'b10, 3, 3, 3, 3, 0, 0);
    play(10);
    plan.delete();
    reset = 1'b1;
    #2;
    check_quiet("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    prev_empty = 1'b1; prev_pause = 1'b0; prev_ph = P_IDLE;
    programme(2'b00, 2'b00, 2, 2, 2, 2, 0, 0); play(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
Program sequencer that times the wash programme and drives the washer actuators: door lock, inlet pump, drain pump, motor. Phases run in this order: lock, fill, wash, drain, refill, rinse, drain, spin, done. Each phase duration comes from the cycle and water-level selects, counted in prescaled time units. The block sits between the front panel (start/abort/selects) and the actuator drivers. It also supervises lid, fill and drain sensors and latches faults.

Parameters:
TICK_DIV, 1000, clk cycles per time unit (>=2)
FILL_TIMEOUT, 60, time units allowed for water_full after entering FILL
DRAIN_TIMEOUT, 30, time units allowed for water_empty after entering DRAIN
RINSE_UNITS, 4, rinse duration in time units

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; sampled only in IDLE
abort  in  1  level; ends the active programme via drain
fault_clr  in  1  leaves FAULT when water_empty=1
cycle_select  in  2  00 quick, 01 normal, 10 heavy, 11 delicate
water_level_select  in  2  00 low, 01 medium, 10/11 high
lid_closed  in  1  lid sensor
water_full  in  1  drum-full sensor
water_empty  in  1  drum-empty sensor
door_locked  out  1  lock solenoid
pump_in  out  1  inlet pump
pump_out  out  1  drain pump
motor_on  out  1  drum motor
phase  out  4  current state code
remaining  out  8  time units left (or timeout units left) in current phase
busy  out  1  state not IDLE/FAULT
done  out  1  one-cycle pulse on entry to IDLE from DONE
fault  out  1  high in FAULT
fault_code  out  2  01 fill timeout, 10 drain timeout, 11 lid open; held until fault_clr

Behaviour:
- Reset: state IDLE (phase 0), all outputs 0, remaining 0, prescaler 0, pass bit 0, fault_code 00.
- Actuator outputs, phase, busy and fault are registered and decoded from the state (Moore). done is a registered pulse.
- State codes: IDLE 0, LOCK 1, FILL 2, WASH 3, DRAIN 4, RINSE 5, SPIN 6, DONE 7, FAULT 8.
- Prescaler counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1. It clears on every state entry, so the first tick comes TICK_DIV cycles after entry.
- Phase entry loads remaining:
  - FILL: FILL_TIMEOUT.
  - WASH: 5, 10, 15 or 8 for cycle_select 00, 01, 10, 11.
  - DRAIN: DRAIN_TIMEOUT.
  - RINSE: RINSE_UNITS.
  - SPIN: 3, 5 or 7 by water level (11 treated as 7).
  - Other states: 0.
- Timed phase (WASH, RINSE, SPIN): on tick, if remaining==1 the phase exits, else remaining decrements. A loaded duration of 0 exits on the first tick.
- Selects are sampled only at phase entry; changes mid-phase are ignored.
- IDLE:
  - start & lid_closed -> LOCK.
  - start & !lid_closed -> FAULT, code 11.
  - Pass bit clears.
- LOCK: door_locked=1 for exactly one cycle, then FILL.
- FILL: pump_in=1. water_full -> WASH if pass=0, RINSE if pass=1. Timeout expiry (remaining reaches 0 on tick) -> FAULT, code 01.
- WASH and RINSE: motor_on=1. On expiry -> DRAIN.
- DRAIN: pump_out=1.
  - water_empty -> FILL with pass=1 if pass was 0; -> SPIN if pass=1.
  - If an abort is latched, water_empty -> IDLE instead, with no done pulse.
  - Timeout -> FAULT, code 10.
- SPIN: motor_on=1 and pump_out=1. On expiry -> DONE.
- DONE: door_locked=0, one cycle, then IDLE; done=1 on that IDLE-entry cycle.
- door_locked=1 in every state from LOCK through SPIN.
- abort in FILL, WASH, RINSE or SPIN -> DRAIN next cycle and latch abort. Abort in DRAIN only latches. The latch clears in IDLE.
- Lid priority: lid_closed=0 in any state LOCK..SPIN -> FAULT, code 11. This has priority over abort, timeout and sensor exits in the same cycle.
- Simultaneous water_full and timeout tick in FILL: water_full wins. The same rule applies to water_empty in DRAIN.
- FAULT:
  - All actuators off, except door_locked = !water_empty.
  - fault_clr & water_empty -> IDLE, fault_code cleared.
  - fault_clr without water_empty is ignored.
- Reset mid-programme returns to IDLE immediately with all actuators off (drum may hold water; the next start refills normally).

Optional Feature:
PAUSE_HOLD_EN
- With the macro defined: adds input port pause (1 bit).
  - While pause=1 in WASH, RINSE or SPIN: prescaler and remaining freeze, motor_on=0, door_locked stays 1.
  - Lid fault and abort still act during pause.
  - pause is ignored in other states.
- Without the macro: no pause port, and timed phases run uninterrupted.

Test Plan:
1. TICK_DIV=4; cycle 00, level 00; start with lid closed; water_full 3 units after FILL entry; water_empty 2 units after each DRAIN entry.
   - Phase order: 1,2,3,4,2,5,4,6,7,0.
   - WASH lasts 20 cycles, SPIN 12 cycles.
   - done pulses once; door_locked drops on DONE.
2. start with lid_closed=0 -> FAULT, fault_code=11, door_locked=0 (drum empty). fault_clr -> IDLE.
3. Hold water_full=0 in FILL, FILL_TIMEOUT=5, TICK_DIV=4 -> FAULT code 01 exactly 20 cycles after FILL entry; pump_in=0 on that cycle.
4. abort at WASH remaining=7 -> DRAIN next cycle. water_empty -> IDLE; no done pulse, no RINSE/SPIN.
5. Lid opens in SPIN on the same cycle as the expiry tick -> FAULT code 11, not DONE.
6. With PAUSE_HOLD_EN, cycle 01: pause high for 9 cycles mid-WASH -> remaining frozen, motor_on=0, WASH exit delayed by exactly 9 cycles.
